// File: rtl/screen_poll_master.sv
// rtl/screen_poll_master.sv - Modbus-RTU read-holding-registers polling master for the screen RS485 link
//
// Purpose: periodically (or on demand) sends an 8-byte function 0x03 request
// for two registers, then collects and validates the 9-byte normal reply or
// the 5-byte exception reply, presenting the payload and one status pulse.
//
// Ports:
//   clk_100m     system clock
//   rst          asynchronous reset, active low
//   poll_en      enables periodic polling every POLL_CYCLES idle cycles
//   poll_now     one-cycle request to start a transaction from IDLE
//   tx_data      byte to transmit, valid while tx_flash=1
//   tx_flash     one-cycle transmit strobe to the UART
//   tx_finish    one-cycle pulse: the byte has left the line
//   rx_data      received byte, valid while rx_flash=1
//   rx_flash     one-cycle receive strobe
//   rd_data      last good payload {d0,d1,d2,d3}
//   rd_valid     one-cycle pulse when rd_data updates
//   err_crc      one-cycle pulse: reply CRC mismatch
//   err_frame    one-cycle pulse: bad address, function or byte count
//   err_exc      one-cycle pulse: exception reply received
//   exc_code     code from the last exception reply
//   err_timeout  one-cycle pulse: TX wait or RX phase ran too long
//   busy         high whenever not IDLE

`timescale 1ns/1ps

module crc16_modbus_step (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

module screen_poll_master #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h01,
  parameter logic [15:0] START_REG      = 16'h0000,
  parameter int unsigned POLL_CYCLES    = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        poll_en,
  input  logic        poll_now,
  output logic [7:0]  tx_data,
  output logic        tx_flash,
  input  logic        tx_finish,
  input  logic [7:0]  rx_data,
  input  logic        rx_flash,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        err_crc,
  output logic        err_frame,
  output logic        err_exc,
  output logic [7:0]  exc_code,
  output logic        err_timeout,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_TX_SEND, S_TX_WAIT, S_RX, S_CHECK} state_t;

  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [31:0] poll_cnt, tmo_cnt;
  logic [3:0]  idx;
  logic [15:0] crc, crc_next;
  logic        is_exc;
  logic [31:0] payload;
  logic [7:0]  code_buf;
  logic [7:0]  tx_byte, crc_din;
  logic        tmo_hit, rx_take, rx_exc_now;
  logic        set_valid, set_crc, set_frame, set_exc, set_tmo;

  // One CRC step serves both directions: request bytes 0..5 while sending,
  // reply bytes while receiving.
  assign crc_din = (state == S_RX) ? rx_data : tx_byte;

  crc16_modbus_step u_crc (
    .crc_in  (crc),
    .data    (crc_din),
    .crc_out (crc_next)
  );

  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign busy       = (state != S_IDLE);
  // Byte 1 decides the frame type in the same cycle it arrives.
  assign rx_exc_now = is_exc | ((idx == 4'd1) && (rx_data == 8'h83));

  always_comb begin
    case (idx)
      4'd0:    tx_byte = SLAVE_ADDR;
      4'd1:    tx_byte = 8'h03;
      4'd2:    tx_byte = START_REG[15:8];
      4'd3:    tx_byte = START_REG[7:0];
      4'd4:    tx_byte = 8'h00;
      4'd5:    tx_byte = 8'h02;
      4'd6:    tx_byte = crc[7:0];
      default: tx_byte = crc[15:8];
    endcase
  end

  always_comb begin
    next_state = state;
    tx_flash   = 1'b0;
    tx_data    = 8'h00;
    rx_take    = 1'b0;
    set_valid  = 1'b0;
    set_crc    = 1'b0;
    set_frame  = 1'b0;
    set_exc    = 1'b0;
    set_tmo    = 1'b0;
    case (state)
      S_IDLE: begin
        if (poll_now || (poll_en && (poll_cnt == POLL_LAST))) next_state = S_TX_SEND;
      end
      S_TX_SEND: begin
        tx_flash   = 1'b1;
        tx_data    = tx_byte;
        next_state = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_finish) begin
          next_state = (idx == 4'd7) ? S_RX : S_TX_SEND;
        end else if (tmo_hit) begin
          set_tmo    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_RX: begin
        if (rx_flash) begin
          if ((idx == 4'd0) && (rx_data != SLAVE_ADDR)) begin
            set_frame = 1'b1;
          end else if ((idx == 4'd1) && (rx_data != 8'h03) && (rx_data != 8'h83)) begin
            set_frame = 1'b1;
          end else if ((idx == 4'd2) && !is_exc && (rx_data != 8'h04)) begin
            set_frame = 1'b1;
          end else begin
            rx_take = 1'b1;
            if (rx_exc_now ? (idx == 4'd4) : (idx == 4'd8)) next_state = S_CHECK;
          end
          if (set_frame) next_state = S_IDLE;
        end else if (tmo_hit) begin
          set_tmo    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_CHECK: begin
        // A valid frame including its own CRC leaves a zero remainder.
        if (crc != 16'h0000) set_crc = 1'b1;
        else if (is_exc)     set_exc = 1'b1;
        else                 set_valid = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      poll_cnt    <= 32'd0;
      tmo_cnt     <= 32'd0;
      idx         <= 4'd0;
      crc         <= 16'h0000;
      is_exc      <= 1'b0;
      payload     <= 32'd0;
      code_buf    <= 8'h00;
      rd_data     <= 32'd0;
      exc_code    <= 8'h00;
      rd_valid    <= 1'b0;
      err_crc     <= 1'b0;
      err_frame   <= 1'b0;
      err_exc     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      rd_valid    <= set_valid;
      err_crc     <= set_crc;
      err_frame   <= set_frame;
      err_exc     <= set_exc;
      err_timeout <= set_tmo;

      if ((state == S_IDLE) && poll_en && (next_state == S_IDLE)) poll_cnt <= poll_cnt + 32'd1;
      else                                                         poll_cnt <= 32'd0;

      // Cleared on every phase entry; an RX phase is timed as a whole.
      if (((state == S_TX_WAIT) || (state == S_RX)) && (next_state == state)) tmo_cnt <= tmo_cnt + 32'd1;
      else                                                                     tmo_cnt <= 32'd0;

      case (state)
        S_IDLE: begin
          idx    <= 4'd0;
          crc    <= 16'hFFFF;
          is_exc <= 1'b0;
        end
        S_TX_SEND: begin
          if (idx < 4'd6) crc <= crc_next;
        end
        S_TX_WAIT: begin
          if (tx_finish) begin
            if (idx == 4'd7) begin
              idx <= 4'd0;
              crc <= 16'hFFFF;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_RX: begin
          if (rx_take) begin
            idx <= idx + 4'd1;
            crc <= crc_next;
            if (idx == 4'd1) is_exc <= (rx_data == 8'h83);
            if (rx_exc_now && (idx == 4'd2)) code_buf <= rx_data;
            if (!rx_exc_now && (idx >= 4'd3) && (idx <= 4'd6)) payload <= {payload[23:0], rx_data};
          end
        end
        S_CHECK: begin
          if (set_valid) rd_data  <= payload;
          if (set_exc)   exc_code <= code_buf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_screen_poll_master.sv
// tb/tb_screen_poll_master.sv - self-checking bench for screen_poll_master

`timescale 1ns/1ps

module tb_screen_poll_master;
  localparam int K_OK = 0, K_CRC = 1, K_FRAME = 2, K_EXC = 3, K_TMO = 4;

  logic        clk_100m = 1'b0;
  logic        rst, poll_en, poll_now, tx_finish, rx_flash, tx_flash;
  logic [7:0]  rx_data, tx_data, exc_code;
  logic [31:0] rd_data;
  logic        rd_valid, err_crc, err_frame, err_exc, err_timeout, busy;

  always #5 clk_100m = ~clk_100m;

  screen_poll_master #(
    .SLAVE_ADDR(8'h01), .START_REG(16'h0000), .POLL_CYCLES(50), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_100m(clk_100m), .rst(rst), .poll_en(poll_en), .poll_now(poll_now),
    .tx_data(tx_data), .tx_flash(tx_flash), .tx_finish(tx_finish),
    .rx_data(rx_data), .rx_flash(rx_flash), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_crc(err_crc), .err_frame(err_frame), .err_exc(err_exc), .exc_code(exc_code),
    .err_timeout(err_timeout), .busy(busy)
  );

  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pulse counters and event timestamps, sampled on the falling edge.
  int cyc = 0, n_valid = 0, n_crc = 0, n_frame = 0, n_exc = 0, n_tmo = 0, n_rise = 0;
  int t_tmo = 0, t_fin = 0, t_flash = 0, t_rise = 0, t_fall = 0;
  logic busy_q = 1'b0;
  always @(negedge clk_100m) begin
    cyc <= cyc + 1;
    busy_q <= busy;
    if (rd_valid)    n_valid <= n_valid + 1;
    if (err_crc)     n_crc   <= n_crc + 1;
    if (err_frame)   n_frame <= n_frame + 1;
    if (err_exc)     n_exc   <= n_exc + 1;
    if (err_timeout) begin n_tmo <= n_tmo + 1; t_tmo <= cyc; end
    if (tx_finish)   t_fin   <= cyc;
    if (tx_flash)    t_flash <= cyc;
    if (busy && !busy_q) begin t_rise <= cyc; n_rise <= n_rise + 1; end
    if (!busy && busy_q) t_fall <= cyc;
  end

  // UART model: logs each transmitted byte, answers tx_finish 10 cycles later.
  bit         uart_answer = 1'b1;
  int         fin_cd = 0, fin_count = 0;
  logic [7:0] tx_log[$];
  initial begin
    tx_finish = 1'b0;
    forever begin
      @(posedge clk_100m); #1;
      tx_finish = 1'b0;
      if (fin_cd > 0) begin
        fin_cd--;
        if (fin_cd == 0) begin tx_finish = 1'b1; fin_count++; end
      end
      if (tx_flash && rst) begin
        tx_log.push_back(tx_data);
        if (uart_answer) fin_cd = 10;
      end
    end
  end

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Reference: classify a reply purely from the protocol rules.
  function automatic int model_kind(input logic [7:0] q[$]);
    int len;
    logic [7:0] f[$];
    if (q.size() < 1) return K_TMO;
    if (q[0] != 8'h01) return K_FRAME;
    if (q.size() < 2) return K_TMO;
    if (q[1] == 8'h83) len = 5;
    else if (q[1] == 8'h03) len = 9;
    else return K_FRAME;
    if (len == 9) begin
      if (q.size() < 3) return K_TMO;
      if (q[2] != 8'h04) return K_FRAME;
    end
    if (q.size() < len) return K_TMO;
    for (int i = 0; i < len; i++) f.push_back(q[i]);
    if (crc16(f) != 16'h0000) return K_CRC;
    return (len == 5) ? K_EXC : K_OK;
  endfunction

  logic [7:0] rq[$];
  logic [7:0] req_exp[8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'hC4, 8'h0B};
  logic [31:0] m_data = 32'd0;
  logic [7:0]  m_code = 8'h00;

  task automatic append_crc();
    logic [15:0] c = crc16(rq);
    rq.push_back(c[7:0]);
    rq.push_back(c[15:8]);
  endtask

  task automatic normal_body(input logic [7:0] fn, input logic [7:0] cnt);
    rq.delete();
    rq.push_back(8'h01); rq.push_back(fn); rq.push_back(cnt);
    repeat (4) rq.push_back(8'($urandom));
    append_crc();
  endtask

  task automatic build_random();
    int sel = $urandom_range(0, 7);
    int n;
    logic [7:0] v;
    case (sel)
      0, 1: normal_body(8'h03, 8'h04);
      2: begin
        rq.delete(); rq.push_back(8'h01); rq.push_back(8'h83); rq.push_back(8'($urandom));
        append_crc();
      end
      3: begin
        normal_body(8'h03, 8'h04);
        n = $urandom_range(3, 8);
        rq[n] = rq[n] ^ (8'h01 << $urandom_range(0, 7));
      end
      4: begin normal_body(8'h03, 8'h04); rq[0] = 8'($urandom_range(2, 255)); end
      5: begin
        v = 8'($urandom); if (v == 8'h03 || v == 8'h83) v = 8'h10;
        normal_body(v, 8'h04);
      end
      6: begin
        v = 8'($urandom); if (v == 8'h04) v = 8'h05;
        normal_body(8'h03, v);
      end
      default: begin
        normal_body(8'h03, 8'h04);
        n = $urandom_range(1, 8);
        while (rq.size() > n) void'(rq.pop_back());
      end
    endcase
  endtask

  task automatic start_txn();
    @(posedge clk_100m); #1; poll_now = 1'b1;
    @(posedge clk_100m); #1; poll_now = 1'b0;
  endtask

  task automatic feed(input logic [7:0] q[$]);
    foreach (q[i]) begin
      repeat (2) @(posedge clk_100m);
      #1; rx_data = q[i]; rx_flash = 1'b1;
      @(posedge clk_100m);
      #1; rx_flash = 1'b0; rx_data = 8'h00;
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk_100m); n++; end
  endtask

  // One full exchange: request bytes, reply, outcome pulses and held outputs.
  task automatic run_vec(input string nm, input logic [7:0] rep[$], input bit echo, input bit self_start,
                         input int kind, input logic [31:0] exp_data, input logic [7:0] exp_code);
    int s_v = n_valid, s_c = n_crc, s_f = n_frame, s_e = n_exc, s_t = n_tmo;
    int base = fin_count, w = 0, d;
    if (self_start) begin tx_log.delete(); start_txn(); end
    while ((fin_count - base) < 8 && w < 400) begin
      @(posedge clk_100m); #1; w++;
      if (echo && tx_log.size() < 8 && (w % 5 == 0)) begin rx_data = 8'h02; rx_flash = 1'b1; end
      else begin rx_flash = 1'b0; rx_data = 8'h00; end
    end
    rx_flash = 1'b0;
    check({nm, "/tx_finishes"}, fin_count - base, 8);
    check({nm, "/tx_len"}, tx_log.size(), 8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++) check($sformatf("%s/tx%0d", nm, i), tx_log[i], req_exp[i]);
    feed(rep);
    wait_idle(2000);
    repeat (2) @(negedge clk_100m);
    #1;
    check({nm, "/rd_valid"},  n_valid - s_v, (kind == K_OK));
    check({nm, "/err_crc"},   n_crc - s_c,   (kind == K_CRC));
    check({nm, "/err_frame"}, n_frame - s_f, (kind == K_FRAME));
    check({nm, "/err_exc"},   n_exc - s_e,   (kind == K_EXC));
    check({nm, "/err_tmo"},   n_tmo - s_t,   (kind == K_TMO));
    check({nm, "/rd_data"},   rd_data, exp_data);
    check({nm, "/exc_code"},  exc_code, exp_code);
    check({nm, "/busy"},      busy, 1'b0);
    if (kind == K_TMO) begin
      d = t_tmo - t_fin;
      check({nm, "/rx_tmo_time"}, (d >= 995 && d <= 1005), 1'b1);
    end
  endtask

  typedef struct {
    logic [71:0] b; int len; bit fix; int kind; logic [31:0] data; logic [7:0] code;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, s, g;
    tbl[0] = '{72'h01_03_04_12_34_56_78_00_00, 7, 1'b1, K_OK,    32'h12345678, 8'h00};
    tbl[1] = '{72'h01_03_04_00_00_00_00_FA_34, 9, 1'b0, K_CRC,   32'h12345678, 8'h00};
    tbl[2] = '{72'h01_83_02_C0_F1_00_00_00_00, 5, 1'b0, K_EXC,   32'h12345678, 8'h02};
    tbl[3] = '{72'h0,                          0, 1'b0, K_TMO,   32'h12345678, 8'h02};
    tbl[4] = '{72'h02_03_04_11_22_33_44_55_66, 9, 1'b0, K_FRAME, 32'h12345678, 8'h02};
    tbl[5] = '{72'h01_04_04_11_22_33_44_55_66, 9, 1'b0, K_FRAME, 32'h12345678, 8'h02};
    tbl[6] = '{72'h01_03_02_11_22_33_44_55_66, 9, 1'b0, K_FRAME, 32'h12345678, 8'h02};
    tbl[7] = '{72'h01_03_04_AB_CD_EF_01_00_00, 7, 1'b1, K_OK,    32'hABCDEF01, 8'h02};

    rst = 1'b0; poll_en = 1'b0; poll_now = 1'b0; rx_flash = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk_100m);
    #1;
    check("reset/busy", busy, 1'b0);
    check("reset/rd_data", rd_data, 32'd0);
    check("reset/exc_code", exc_code, 8'h00);
    check("reset/pulses", {tx_flash, rd_valid, err_crc, err_frame, err_exc, err_timeout}, 6'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk_100m);

    foreach (tbl[v]) begin
      rq.delete();
      for (int i = 0; i < tbl[v].len; i++) rq.push_back(tbl[v].b[71 - 8*i -: 8]);
      if (tbl[v].fix) append_crc();
      run_vec($sformatf("vec%0d", v), rq, 1'b0, 1'b1, tbl[v].kind, tbl[v].data, tbl[v].code);
    end
    m_data = tbl[7].data; m_code = tbl[7].code;

    // Local echo of our own request must not disturb the exchange.
    rq.delete(); rq = '{8'h01, 8'h03, 8'h04, 8'h5A, 8'hA5, 8'h0F, 8'hF0}; append_crc();
    m_data = 32'h5AA50FF0;
    run_vec("echo", rq, 1'b1, 1'b1, K_OK, m_data, m_code);

    // UART never confirms the first byte: timeout out of the TX wait.
    uart_answer = 1'b0;
    s = n_tmo; k = n_valid + n_crc + n_frame + n_exc;
    tx_log.delete();
    start_txn();
    @(negedge clk_100m);
    wait_idle(1500);
    repeat (2) @(negedge clk_100m);
    #1;
    check("txtmo/err_tmo", n_tmo - s, 1);
    check("txtmo/others", n_valid + n_crc + n_frame + n_exc - k, 0);
    check("txtmo/tx_len", tx_log.size(), 1);
    d = t_tmo - t_flash;
    check("txtmo/time", (d >= 995 && d <= 1005), 1'b1);
    check("txtmo/rd_data", rd_data, m_data);
    uart_answer = 1'b1;
    fin_cd = 0;

    for (int i = 0; i < 24; i++) begin
      build_random();
      k = model_kind(rq);
      if (k == K_OK)  m_data = {rq[3], rq[4], rq[5], rq[6]};
      if (k == K_EXC) m_code = rq[2];
      run_vec($sformatf("rand%0d", i), rq, 1'b0, 1'b1, k, m_data, m_code);
    end

    // Periodic polling: 50 idle cycles between transactions.
    tx_log.delete();
    poll_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      g = 0;
      while (!busy && g < 200) begin @(negedge clk_100m); g++; end
      #1;
      check($sformatf("poll%0d/started", p), busy, 1'b1);
      if (p > 0) check($sformatf("poll%0d/gap", p), t_rise - t_fall, 50);
      if (p == 2) poll_en = 1'b0;
      normal_body(8'h03, 8'h04);
      m_data = {rq[3], rq[4], rq[5], rq[6]};
      run_vec($sformatf("poll%0d", p), rq, 1'b0, 1'b0, K_OK, m_data, m_code);
      tx_log.delete();
    end
    s = n_rise;
    repeat (200) @(negedge clk_100m);
    #1;
    check("poll_off/no_start", n_rise - s, 0);

    // Reset in the middle of a reply: everything clears at once, no pulse.
    s = n_valid + n_crc + n_frame + n_exc + n_tmo;
    tx_log.delete();
    start_txn();
    g = 0;
    while (tx_log.size() < 8 && g < 400) begin @(posedge clk_100m); g++; end
    repeat (15) @(posedge clk_100m);
    rq = '{8'h01, 8'h03, 8'h04};
    feed(rq);
    #2; rst = 1'b0;
    #1;
    check("midrst/busy", busy, 1'b0);
    check("midrst/rd_data", rd_data, 32'd0);
    check("midrst/exc_code", exc_code, 8'h00);
    check("midrst/outs", {tx_data, tx_flash, rd_valid, err_crc, err_frame, err_exc, err_timeout}, 14'd0);
    repeat (3) @(posedge clk_100m);
    #1; rst = 1'b1;
    repeat (3) @(negedge clk_100m);
    #1;
    check("midrst/no_pulse", n_valid + n_crc + n_frame + n_exc + n_tmo - s, 0);
    m_data = 32'd0; m_code = 8'h00;
    normal_body(8'h03, 8'h04);
    m_data = {rq[3], rq[4], rq[5], rq[6]};
    run_vec("after_rst", rq, 1'b0, 1'b1, K_OK, m_data, m_code);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
